instr_issue_ctrl: RTL and testbench

Sequences instruction delivery from the instruction-memory response path into the instruction decoder. It buffers fetched instructions in a small FIFO and applies decode stalls. It drives the decoder's flush input during boot, on branch/jump redirects and on traps, and discards wrong-path fetch responses for a fixed window after each redirect.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/instr_skid_fifo.sv | 68 ++++++
 rtl/instr_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_instr_issue_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and the issue-controller state encoding for the fetch/decode front end.
package riscv_pkg;

  localparam int          XLEN_DEF  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } issue_state_e;

endpackage

// File: rtl/instr_skid_fifo.sv
// Small power-of-two FIFO between the fetch response path and the decoder.
// A synchronous clear empties it without touching the stored words.
module instr_skid_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_issue_ctrl.sv
// Issue controller: boot flush, redirect/trap wrong-path discard, FIFO-buffered issue to decode.
// Define FLUSH_STATS_EN to add the saturating flush_cnt_out statistics port.
module instr_issue_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int DEPTH        = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int BOOT_CYCLES  = 4
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            imem_valid_in,
  input  logic [XLEN-1:0] imem_instr_in,
  input  logic [XLEN-1:0] imem_pc_in,
  output logic            imem_ready_out,
  input  logic            redirect_in,
  input  logic            trap_in,
  input  logic            stall_in,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            flush_out,
  output logic            valid_out
`ifdef FLUSH_STATS_EN
  ,
  output logic [15:0]     flush_cnt_out
`endif
);

  localparam int CNT_MAX = (BOOT_CYCLES > FLUSH_CYCLES) ? BOOT_CYCLES : FLUSH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  issue_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               kill, fifo_clear, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [2*XLEN-1:0]  fifo_head;

  assign kill = redirect_in | trap_in;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    fifo_clear     = 1'b0;
    imem_ready_out = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        if (cnt_q == '0) state_d = S_RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RUN: begin
        imem_ready_out = ~fifo_full;
        if (kill) begin
          fifo_clear = 1'b1;
          cnt_d      = CNT_W'(FLUSH_CYCLES - 1);
          state_d    = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Everything offered here is wrong-path: accept it so fetch drains, then drop it.
        imem_ready_out = 1'b1;
        if (kill) begin
          fifo_clear = 1'b1;
          cnt_d      = CNT_W'(FLUSH_CYCLES - 1);
        end else if (cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_BOOT;
        cnt_d   = CNT_W'(BOOT_CYCLES - 1);
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_BOOT;
      cnt_q   <= CNT_W'(BOOT_CYCLES - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo_push = (state_q == S_RUN) & imem_valid_in & imem_ready_out & ~kill;
  assign flush_out = (state_q != S_RUN) | fifo_empty | kill;
  assign valid_out = ~flush_out;
  assign fifo_pop  = valid_out & ~stall_in;
  assign instr_out = valid_out ? fifo_head[XLEN-1:0]      : XLEN'(NOP_INSTR);
  assign pc_out    = valid_out ? fifo_head[2*XLEN-1:XLEN] : '0;

  instr_skid_fifo #(
    .W     (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clear_i (fifo_clear),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({imem_pc_in, imem_instr_in}),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef FLUSH_STATS_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (flush_out && (state_q != S_BOOT) && (flush_cnt_q != 16'hFFFF))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) flush_cnt_q <= '0;
    else        flush_cnt_q <= flush_cnt_d;
  end

  assign flush_cnt_out = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Bench for instr_issue_ctrl: directed vector table, async-reset sequence, random run vs. queue model.
module tb_instr_issue_ctrl;
  import riscv_pkg::*;

  localparam int XLEN = 32, DEPTH = 2, FLUSH_CYCLES = 2, BOOT_CYCLES = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            imem_valid_in, redirect_in, trap_in, stall_in;
  logic [XLEN-1:0] imem_instr_in, imem_pc_in;
  logic            imem_ready_out, flush_out, valid_out;
  logic [XLEN-1:0] instr_out, pc_out;
`ifdef FLUSH_STATS_EN
  logic [15:0]     flush_cnt_out;
`endif

  instr_issue_ctrl #(
    .XLEN(XLEN), .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .BOOT_CYCLES(BOOT_CYCLES)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .imem_valid_in(imem_valid_in), .imem_instr_in(imem_instr_in), .imem_pc_in(imem_pc_in),
    .imem_ready_out(imem_ready_out), .redirect_in(redirect_in), .trap_in(trap_in),
    .stall_in(stall_in), .instr_out(instr_out), .pc_out(pc_out),
    .flush_out(flush_out), .valid_out(valid_out)
`ifdef FLUSH_STATS_EN
    , .flush_cnt_out(flush_cnt_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending instructions plus remaining boot/flush cycle counts.
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t q[$];
  int   boot_left, flush_left;

  task automatic model_reset();
    q.delete();
    boot_left  = BOOT_CYCLES;
    flush_left = 0;
  endtask

  task automatic model_outs(output logic rdy, output logic fl, output logic vl,
                            output logic [31:0] ins, output logic [31:0] pc);
    fl  = (boot_left > 0) || (flush_left > 0) || (q.size() == 0) || redirect_in || trap_in;
    vl  = !fl;
    rdy = (boot_left > 0) ? 1'b0 : (flush_left > 0) ? 1'b1 : (q.size() < DEPTH);
    ins = vl ? q[0].instr : NOP;
    pc  = vl ? q[0].pc : 32'h0;
  endtask

  task automatic model_update();
    bit   do_push, do_pop;
    ent_t e;
    if (boot_left > 0) boot_left--;
    else if (redirect_in || trap_in) begin
      q.delete();
      flush_left = FLUSH_CYCLES;
    end else if (flush_left > 0) flush_left--;
    else begin
      do_push = imem_valid_in && (q.size() < DEPTH);
      do_pop  = (q.size() > 0) && !stall_in;
      if (do_pop) e = q.pop_front();
      if (do_push) begin
        e.instr = imem_instr_in;
        e.pc    = imem_pc_in;
        q.push_back(e);
      end
    end
  endtask

  task automatic drive(input logic r, input logic t, input logic s, input logic v,
                       input logic [31:0] ins, input logic [31:0] pc);
    redirect_in = r; trap_in = t; stall_in = s; imem_valid_in = v;
    imem_instr_in = ins; imem_pc_in = pc;
    @(negedge clk_in);
  endtask

  task automatic advance();
    @(posedge clk_in);
    model_update();
    #1;
  endtask

  task automatic check_vs_model(input string tag);
    logic rdy, fl, vl;
    logic [31:0] ins, pc;
    model_outs(rdy, fl, vl, ins, pc);
    chk({tag, ".ready"}, {31'b0, imem_ready_out}, {31'b0, rdy});
    chk({tag, ".flush"}, {31'b0, flush_out}, {31'b0, fl});
    chk({tag, ".valid"}, {31'b0, valid_out}, {31'b0, vl});
    chk({tag, ".instr"}, instr_out, ins);
    chk({tag, ".pc"}, pc_out, pc);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".ready"}, {31'b0, imem_ready_out}, 32'd0);
    chk({tag, ".flush"}, {31'b0, flush_out}, 32'd1);
    chk({tag, ".valid"}, {31'b0, valid_out}, 32'd0);
    chk({tag, ".instr"}, instr_out, NOP);
    chk({tag, ".pc"}, pc_out, 32'h0);
  endtask

  typedef struct {
    logic r, t, s, v;
    logic [31:0] ins, pc;
    logic e_rdy, e_fl, e_vld;
    logic [31:0] e_ins, e_pc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic t, input logic s, input logic v,
                              input logic [31:0] ins, input logic [31:0] pc,
                              input logic e_rdy, input logic e_fl, input logic e_vld,
                              input logic [31:0] e_ins, input logic [31:0] e_pc);
    vec_t x;
    x.r = r; x.t = t; x.s = s; x.v = v; x.ins = ins; x.pc = pc;
    x.e_rdy = e_rdy; x.e_fl = e_fl; x.e_vld = e_vld; x.e_ins = e_ins; x.e_pc = e_pc;
    return x;
  endfunction

  localparam logic [31:0] I0 = 32'h00500093, IA = 32'h00100113, IB = 32'h00200193,
                          IC = 32'h00300213, ID = 32'h00400293, IH = 32'h00500313,
                          II = 32'h00600393, IX = 32'hDEADBEEF;

  vec_t tbl[23];

  initial begin
    // Boot window, single issue, stall/full back-pressure, redirect on full FIFO, trap+redirect under stall.
    tbl[0]  = mk(0,0,0,0, 0,   0,      0,1,0, NOP, 0);
    tbl[1]  = mk(0,0,0,0, 0,   0,      0,1,0, NOP, 0);
    tbl[2]  = mk(0,0,0,0, 0,   0,      0,1,0, NOP, 0);
    tbl[3]  = mk(1,1,0,1, IX,  'h50,   0,1,0, NOP, 0);
    tbl[4]  = mk(0,0,0,1, I0,  'h100,  1,1,0, NOP, 0);
    tbl[5]  = mk(0,0,0,0, 0,   0,      1,0,1, I0,  'h100);
    tbl[6]  = mk(0,0,1,1, IA,  'h104,  1,1,0, NOP, 0);
    tbl[7]  = mk(0,0,1,1, IB,  'h108,  1,0,1, IA,  'h104);
    tbl[8]  = mk(0,0,1,1, IC,  'h10C,  0,0,1, IA,  'h104);
    tbl[9]  = mk(0,0,0,1, IC,  'h10C,  0,0,1, IA,  'h104);
    tbl[10] = mk(0,0,0,1, IC,  'h10C,  1,0,1, IB,  'h108);
    tbl[11] = mk(0,0,1,1, ID,  'h110,  1,0,1, IC,  'h10C);
    tbl[12] = mk(0,0,1,0, 0,   0,      0,0,1, IC,  'h10C);
    tbl[13] = mk(1,0,1,1, IX,  'h114,  0,1,0, NOP, 0);
    tbl[14] = mk(0,0,0,1, IX,  'h200,  1,1,0, NOP, 0);
    tbl[15] = mk(0,0,0,1, IX,  'h204,  1,1,0, NOP, 0);
    tbl[16] = mk(0,0,0,1, IH,  'h208,  1,1,0, NOP, 0);
    tbl[17] = mk(0,0,0,0, 0,   0,      1,0,1, IH,  'h208);
    tbl[18] = mk(0,0,1,1, II,  'h20C,  1,1,0, NOP, 0);
    tbl[19] = mk(1,1,1,1, IX,  'h210,  1,1,0, NOP, 0);
    tbl[20] = mk(0,0,1,0, 0,   0,      1,1,0, NOP, 0);
    tbl[21] = mk(0,0,1,0, 0,   0,      1,1,0, NOP, 0);
    tbl[22] = mk(0,0,0,0, 0,   0,      1,1,0, NOP, 0);

    rst_in = 1'b1;
    redirect_in = 0; trap_in = 0; stall_in = 0; imem_valid_in = 0;
    imem_instr_in = '0; imem_pc_in = '0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    check_reset_vals("reset");
    rst_in = 1'b0;

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].v, tbl[i].ins, tbl[i].pc);
      chk($sformatf("vec%0d.ready", i), {31'b0, imem_ready_out}, {31'b0, tbl[i].e_rdy});
      chk($sformatf("vec%0d.flush", i), {31'b0, flush_out}, {31'b0, tbl[i].e_fl});
      chk($sformatf("vec%0d.valid", i), {31'b0, valid_out}, {31'b0, tbl[i].e_vld});
      chk($sformatf("vec%0d.instr", i), instr_out, tbl[i].e_ins);
      chk($sformatf("vec%0d.pc", i), pc_out, tbl[i].e_pc);
      advance();
    end

    // Asynchronous reset in the middle of a flush window, with no clock edge.
    drive(1, 0, 0, 1, IX, 'h300);
    advance();
    drive(0, 0, 0, 1, IX, 'h304);
    chk("midflush.ready", {31'b0, imem_ready_out}, 32'd1);
    chk("midflush.flush", {31'b0, flush_out}, 32'd1);
    #2 rst_in = 1'b1;
    #1 check_reset_vals("async_rst");
    model_reset();
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      check_vs_model($sformatf("reboot%0d", i));
      chk($sformatf("reboot%0d.ready_exp", i), {31'b0, imem_ready_out}, {31'b0, (i >= BOOT_CYCLES)});
      advance();
    end

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0),
            $urandom, $urandom & 32'hFFFF_FFFC);
      check_vs_model($sformatf("rand%0d", i));
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
